// File: rtl/hc_down_counter_pkg.sv
// hc_down_counter_pkg
// Shared definitions for the presettable down-counter:
//   - NIB_W        : width of one counter stage (4 bits)
//   - mode_e       : underflow mode encodings carried on MODE
//   - state_e      : RUN/HALT state of the one-shot control FSM
package hc_down_counter_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_RELOAD  = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11   // behaves as WRAP
    } mode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

endpackage

// File: rtl/hc_nibble_dn.sv
// hc_nibble_dn
// One 4-bit down-counting stage with its own register.
// Ports:
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset (clears the stage)
//   load  in   load d into the stage (wins over dec)
//   d     in   load value
//   dec   in   decrement this edge (borrow-in from lower stages)
//   q     out  stage value
//   zero  out  stage == 0, i.e. borrow-out toward the next stage
module hc_nibble_dn
    import hc_down_counter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [NIB_W-1:0] d,
    input  logic             dec,
    output logic [NIB_W-1:0] q,
    output logic             zero
);

    logic [NIB_W-1:0] q_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else if (load) begin
            q_q <= d;
        end else if (dec) begin
            q_q <= q_q - NIB_W'(1);
        end
    end

    assign q    = q_q;
    assign zero = (q_q == '0);

endmodule

// File: rtl/hc_down_counter.sv
// hc_down_counter
// Presettable down-counter built from NIBBLES chained 4-bit stages.
// Ports:
//   CP      in   clock, rising edge
//   MR      in   synchronous active-high master reset
//   PEN     in   active-low parallel load of Dn (also sets reload register)
//   Dn      in   parallel load data, W = 4*NIBBLES bits
//   CEP/CET in   count enables; CET also gates TC
//   MODE    in   underflow mode: WRAP, RELOAD, ONESHOT (11 = WRAP)
//   Qn      out  current count
//   TC      out  combinational terminal count, CET & (Qn == 0)
//   BO      out  registered one-cycle borrow pulse after an underflow
//   HALTED  out  high while stopped after a ONESHOT underflow
module hc_down_counter
    import hc_down_counter_pkg::*;
#(
    parameter int unsigned NIBBLES = 2
) (
    input  logic                     CP,
    input  logic                     MR,
    input  logic                     PEN,
    input  logic [NIBBLES*NIB_W-1:0] Dn,
    input  logic                     CEP,
    input  logic                     CET,
    input  logic [1:0]               MODE,
    output logic [NIBBLES*NIB_W-1:0] Qn,
    output logic                     TC,
    output logic                     BO,
    output logic                     HALTED
);

    localparam int unsigned W = NIBBLES * NIB_W;

    state_e         state_q, state_d;
    logic [W-1:0]   reload_q;
    logic           bo_q, bo_d;

    logic           load;
    logic           count_en;
    logic           underflow;
    logic           reload_uf;
    logic           oneshot_uf;
    logic           stage_load;
    logic [W-1:0]   stage_val;

    logic [NIBBLES-1:0] zero;
    // chain[k]: count enabled and every stage below k is zero
    logic [NIBBLES:0]   chain;

    assign load      = ~PEN;
    assign count_en  = CEP & CET & (state_q == ST_RUN);
    assign chain[0]  = count_en;
    assign underflow = chain[NIBBLES];

    always_comb begin
        reload_uf  = 1'b0;
        oneshot_uf = 1'b0;
        unique case (mode_e'(MODE))
            MODE_RELOAD:  reload_uf  = underflow;
            MODE_ONESHOT: oneshot_uf = underflow;
            // WRAP needs nothing: decrementing 0 in every stage yields all ones
            default: ;
        endcase
    end

    // RELOAD underflow reuses the stage load path with the reload value
    assign stage_load = load | reload_uf;
    assign stage_val  = load ? Dn : reload_q;

    for (genvar k = 0; k < NIBBLES; k++) begin : g_stage
        assign chain[k+1] = chain[k] & zero[k];

        hc_nibble_dn u_stage (
            .clk  (CP),
            .rst  (MR),
            .load (stage_load),
            .d    (stage_val[k*NIB_W +: NIB_W]),
            // ONESHOT underflow holds the count at 0
            .dec  (chain[k] & ~oneshot_uf),
            .q    (Qn[k*NIB_W +: NIB_W]),
            .zero (zero[k])
        );
    end

    always_comb begin
        state_d = state_q;
        bo_d    = 1'b0;
        if (load) begin
            state_d = ST_RUN;
        end else begin
            bo_d = underflow;
            if (oneshot_uf) begin
                state_d = ST_HALT;
            end
        end
    end

    always_ff @(posedge CP) begin
        if (MR) begin
            state_q  <= ST_RUN;
            reload_q <= '0;
            bo_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            bo_q    <= bo_d;
            if (load) begin
                reload_q <= Dn;
            end
        end
    end

    assign TC     = CET & (&zero);
    assign BO     = bo_q;
    assign HALTED = (state_q == ST_HALT);

endmodule

// File: tb/tb_hc_down_counter.sv
module tb_hc_down_counter;

    localparam int NIBBLES = 2;
    localparam int W = 4 * NIBBLES;
    localparam int MAXV = (1 << W) - 1;

    logic         CP = 1'b0;
    logic         MR, PEN, CEP, CET;
    logic [W-1:0] Dn;
    logic [1:0]   MODE;
    logic [W-1:0] Qn;
    logic         TC, BO, HALTED;

    int checks = 0;
    int errors = 0;

    hc_down_counter #(.NIBBLES(NIBBLES)) dut (
        .CP     (CP),
        .MR     (MR),
        .PEN    (PEN),
        .Dn     (Dn),
        .CEP    (CEP),
        .CET    (CET),
        .MODE   (MODE),
        .Qn     (Qn),
        .TC     (TC),
        .BO     (BO),
        .HALTED (HALTED)
    );

    always #5 CP = ~CP;

    typedef struct {
        logic         mr;
        logic         pen;
        logic [W-1:0] d;
        logic         cep;
        logic         cet;
        logic [1:0]   mode;
        logic [W-1:0] q;
        logic         tc;
        logic         bo;
        logic         halted;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s #%0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic mr, input logic pen, input logic [W-1:0] d,
                       input logic cep, input logic cet, input logic [1:0] mode,
                       input logic [W-1:0] q, input logic tc, input logic bo,
                       input logic halted);
        vec_t v;
        v.mr = mr; v.pen = pen; v.d = d; v.cep = cep; v.cet = cet; v.mode = mode;
        v.q = q; v.tc = tc; v.bo = bo; v.halted = halted;
        vecs.push_back(v);
    endtask

    // Drive one edge's inputs, then sample outputs shortly after the edge.
    task automatic apply(input logic mr, input logic pen, input logic [W-1:0] d,
                         input logic cep, input logic cet, input logic [1:0] mode);
        MR = mr; PEN = pen; Dn = d; CEP = cep; CET = cet; MODE = mode;
        @(posedge CP);
        #1;
    endtask

    // Behavioural reference state
    int m_q, m_rl;
    bit m_bo, m_halt;

    task automatic model_edge(input logic mr, input logic pen, input logic [W-1:0] d,
                              input logic cep, input logic cet, input logic [1:0] mode);
        if (mr) begin
            m_q = 0; m_rl = 0; m_bo = 0; m_halt = 0;
        end else if (!pen) begin
            m_q = int'(d); m_rl = int'(d); m_bo = 0; m_halt = 0;
        end else if (cep && cet && !m_halt) begin
            if (m_q != 0) begin
                m_q = m_q - 1; m_bo = 0;
            end else begin
                m_bo = 1;
                if (mode == 2'b01)      m_q = m_rl;
                else if (mode == 2'b10) m_halt = 1;
                else                    m_q = MAXV;
            end
        end else begin
            m_bo = 0;
        end
    endtask

    initial begin
        MR = 1'b1; PEN = 1'b1; Dn = '0; CEP = 1'b0; CET = 1'b0; MODE = 2'b00;

        //   mr pen d      cep cet mode   q      tc bo h
        // reset
        add(1, 1, 8'h00, 0, 1, 2'b00, 8'h00, 1, 0, 0);
        // load 03, count into WRAP
        add(0, 0, 8'h03, 0, 1, 2'b00, 8'h03, 0, 0, 0);
        add(0, 1, 8'h00, 1, 1, 2'b00, 8'h02, 0, 0, 0);
        add(0, 1, 8'h00, 1, 1, 2'b00, 8'h01, 0, 0, 0);
        add(0, 1, 8'h00, 1, 1, 2'b00, 8'h00, 1, 0, 0);
        add(0, 1, 8'h00, 1, 1, 2'b00, 8'hFF, 0, 1, 0);
        add(0, 1, 8'h00, 1, 1, 2'b00, 8'hFE, 0, 0, 0);
        // nibble borrow
        add(0, 0, 8'h10, 1, 1, 2'b00, 8'h10, 0, 0, 0);
        add(0, 1, 8'h00, 1, 1, 2'b00, 8'h0F, 0, 0, 0);
        add(0, 0, 8'h00, 1, 1, 2'b00, 8'h00, 1, 0, 0);
        add(0, 1, 8'h00, 1, 1, 2'b11, 8'hFF, 0, 1, 0);
        // RELOAD with 02
        add(0, 0, 8'h02, 1, 1, 2'b01, 8'h02, 0, 0, 0);
        add(0, 1, 8'h00, 1, 1, 2'b01, 8'h01, 0, 0, 0);
        add(0, 1, 8'h00, 1, 1, 2'b01, 8'h00, 1, 0, 0);
        add(0, 1, 8'h00, 1, 1, 2'b01, 8'h02, 0, 1, 0);
        add(0, 1, 8'h00, 1, 1, 2'b01, 8'h01, 0, 0, 0);
        add(0, 1, 8'h00, 1, 1, 2'b01, 8'h00, 1, 0, 0);
        add(0, 1, 8'h00, 1, 1, 2'b01, 8'h02, 0, 1, 0);
        // RELOAD with 0: borrow every enabled cycle
        add(0, 0, 8'h00, 1, 1, 2'b01, 8'h00, 1, 0, 0);
        add(0, 1, 8'h00, 1, 1, 2'b01, 8'h00, 1, 1, 0);
        add(0, 1, 8'h00, 1, 1, 2'b01, 8'h00, 1, 1, 0);
        // ONESHOT
        add(0, 0, 8'h01, 1, 1, 2'b10, 8'h01, 0, 0, 0);
        add(0, 1, 8'h00, 1, 1, 2'b10, 8'h00, 1, 0, 0);
        add(0, 1, 8'h00, 1, 1, 2'b10, 8'h00, 1, 1, 1);
        add(0, 1, 8'h00, 1, 1, 2'b10, 8'h00, 1, 0, 1);
        add(0, 1, 8'h00, 1, 1, 2'b00, 8'h00, 1, 0, 1);
        add(0, 0, 8'h05, 1, 1, 2'b10, 8'h05, 0, 0, 0);
        add(0, 1, 8'h00, 1, 1, 2'b10, 8'h04, 0, 0, 0);
        // load beats simultaneous underflow; no HALT
        add(0, 0, 8'h00, 0, 1, 2'b10, 8'h00, 1, 0, 0);
        add(0, 0, 8'h07, 1, 1, 2'b10, 8'h07, 0, 0, 0);
        // gating
        add(0, 1, 8'h00, 1, 0, 2'b00, 8'h07, 0, 0, 0);
        add(0, 0, 8'h00, 1, 0, 2'b00, 8'h00, 0, 0, 0);
        add(0, 1, 8'h00, 0, 1, 2'b00, 8'h00, 1, 0, 0);
        // MR in HALT
        add(0, 1, 8'h00, 1, 1, 2'b10, 8'h00, 1, 1, 1);
        add(1, 1, 8'h00, 1, 1, 2'b10, 8'h00, 1, 0, 0);
        // MR mid-count
        add(0, 0, 8'h55, 1, 1, 2'b00, 8'h55, 0, 0, 0);
        add(0, 1, 8'h00, 1, 1, 2'b00, 8'h54, 0, 0, 0);
        add(1, 0, 8'h33, 1, 1, 2'b00, 8'h00, 1, 0, 0);

        foreach (vecs[i]) begin
            apply(vecs[i].mr, vecs[i].pen, vecs[i].d, vecs[i].cep, vecs[i].cet, vecs[i].mode);
            check("vec_q", i, 32'(Qn), 32'(vecs[i].q));
            check("vec_tc", i, 32'(TC), 32'(vecs[i].tc));
            check("vec_bo", i, 32'(BO), 32'(vecs[i].bo));
            check("vec_halted", i, 32'(HALTED), 32'(vecs[i].halted));
        end

        // TC drops with CET in the same cycle, no edge needed
        CET = 1'b0;
        #1;
        check("tc_cet_drop", 0, 32'(TC), 32'(0));
        CET = 1'b1;
        #1;
        check("tc_cet_rise", 0, 32'(TC), 32'(1));

        // Randomized run against the reference model
        begin
            logic         r_mr, r_pen, r_cep, r_cet;
            logic [W-1:0] r_d;
            logic [1:0]   r_mode;
            m_q = 0; m_rl = 0; m_bo = 0; m_halt = 0;
            apply(1, 1, '0, 0, 0, 2'b00);
            for (int n = 0; n < 3000; n++) begin
                r_mr   = ($urandom_range(0, 63) == 0);
                r_pen  = ($urandom_range(0, 11) != 0);
                r_cep  = ($urandom_range(0, 7) != 0);
                r_cet  = ($urandom_range(0, 7) != 0);
                r_mode = 2'($urandom_range(0, 3));
                r_d    = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 4))
                                                     : W'($urandom);
                model_edge(r_mr, r_pen, r_d, r_cep, r_cet, r_mode);
                apply(r_mr, r_pen, r_d, r_cep, r_cet, r_mode);
                check("rnd_q", n, 32'(Qn), 32'(m_q));
                check("rnd_tc", n, 32'(TC), 32'((r_cet && m_q == 0) ? 1 : 0));
                check("rnd_bo", n, 32'(BO), 32'(m_bo));
                check("rnd_halted", n, 32'(HALTED), 32'(m_halt));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hc_down_counter.md
# hc_down_counter

Synchronous presettable down-counter, the count-down counterpart of the team's 74HC161-style up-counter, built from chained 4-bit nibble stages. Used as the loop/step counter and delay timer beside the program counter in the cpu74hc161 datapath. Supports parallel load, a reload register, three underflow modes, a cascadable ripple-free terminal-count output and a one-cycle borrow pulse.

## Interface
- NIBBLES, 2, number of 4-bit stages; counter width W = 4*NIBBLES.
- CP  in  1  clock; all state updates on rising edge.
- MR  in  1  master reset, synchronous, active-high.
- PEN  in  1  parallel enable, active-low; loads Dn into Qn and into the reload register.
- Dn  in  W  parallel load data.
- CEP  in  1  count enable (parallel).
- CET  in  1  count enable (trickle); also gates TC for cascading.
- MODE  in  2  underflow mode: 00 WRAP, 01 RELOAD, 10 ONESHOT, 11 treated as WRAP.
- Qn  out  W  current count.
- TC  out  1  terminal count, combinational: CET & (Qn == 0).
- BO  out  1  borrow pulse, registered, one cycle.
- HALTED  out  1  high while the counter is halted in ONESHOT mode.

## Operation
- Priority per edge: MR > load (!PEN) > count (CEP & CET & !HALTED) > hold.
- MR: Qn=0, reload register=0, BO=0, state=RUN (HALTED=0).
- Load: Qn<=Dn, reload register<=Dn, state<=RUN, BO<=0. Load also exits HALT.
- Count with Qn != 0: Qn<=Qn-1, BO<=0.
- Count with Qn == 0 (underflow event), by MODE sampled on the same edge:
  - WRAP: Qn<=all ones (2^W-1), BO<=1.
  - RELOAD: Qn<=reload register, BO<=1. Reload value 0 gives BO on every enabled cycle.
  - ONESHOT: Qn holds 0, BO<=1, state<=HALT.
- HALT: count enables ignored; Qn holds; BO=0 after its single pulse; left only via load or MR.
- No count (CEP&CET=0): Qn holds, BO<=0.
- FSM states: RUN, HALT. RUN->HALT on ONESHOT underflow; HALT->RUN on load; any->RUN on MR.
- Arithmetic modulo 2^W; borrow ripples between nibble stages combinationally within one cycle; stage k decrements only when all lower stages are 0 and count is enabled.
- Cascading: TC of one instance drives CET of the next; since TC depends on CET, a chain forms a combinational enable path (synthesis constraint, not a functional change).

## Timing
- Load latency: Qn=Dn visible one cycle after the edge sampling !PEN.
- Count latency: one edge per decrement; no pipeline stages.
- TC: combinational; rises in the same cycle Qn becomes 0 (with CET=1); falls immediately if CET drops.
- BO: asserted exactly one cycle, in the cycle following the underflow edge (coincides with the post-underflow Qn).
- Simultaneous load and underflow: load wins, BO=0, no HALT.
- MR mid-count or in HALT: next cycle all outputs at reset values (Qn=0, TC=CET, BO=0, HALTED=0).
- MODE changes take effect on the next underflow edge; no other effect.

## Structure
- Shared package: MODE encodings (MODE_WRAP, MODE_RELOAD, MODE_ONESHOT), FSM state encoding (ST_RUN, ST_HALT), nibble width constant 4.
- Sub-module hc_nibble_dn: 4-bit down stage with load, borrow-in enable, borrow-out (stage==0), holds its own nibble register; instantiated NIBBLES times via generate.
- Top level owns the reload register, FSM, underflow mux and BO register.

## Test plan
- Reset: assert MR 1 cycle during counting -> Qn=0x00, BO=0, HALTED=0 next cycle; TC=1 when CET=1.
- Load/count, NIBBLES=2: PEN low with Dn=0x03, then CEP=CET=1 for 4 cycles -> Qn 03,02,01,00,FF (WRAP); TC=1 only while Qn=00; BO=1 only in the FF cycle.
- Nibble borrow: load 0x10, count once -> Qn=0x0F; load 0x00, count -> 0xFF.
- RELOAD: MODE=01, load 0x02, count 6 cycles -> 02,01,00,02,01,00,02; BO pulses twice, each one cycle.
- ONESHOT: MODE=10, load 0x01, count 4 cycles -> 01,00,00,00; BO one pulse; HALTED=1 stays; then PEN low Dn=0x05 -> Qn=05, HALTED=0, counting resumes.
- Priority/gating: Qn=00 with PEN low Dn=0x07 and count enabled -> Qn=07, BO=0; CEP=1,CET=0 -> Qn holds, TC=0.
